// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the 16-bit parallel-to-serial stage.
// Start/final bit indices come from helper functions because bit order is a per-instance parameter.
package bit_serializer_pkg;

    localparam int WORD_W = 16;
    localparam int SEL_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    function automatic logic [SEL_W-1:0] sel_first(input bit msb_first);
        return msb_first ? SEL_W'(WORD_W - 1) : '0;
    endfunction

    function automatic logic [SEL_W-1:0] sel_last(input bit msb_first);
        return msb_first ? '0 : SEL_W'(WORD_W - 1);
    endfunction

endpackage

// File: rtl/bit_serializer16_mux161.sv
// 16:1 bit-select mux: returns word[sel].
module MUX161
    import bit_serializer_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [SEL_W-1:0]  sel,
    output logic              dout
);

    always_comb begin
        dout = word[sel];
    end

endmodule

// File: rtl/bit_serializer16.sv
// Loads a 16-bit word and emits it one bit per accepted beat on a valid/ready stream.
// Optional macro SERIALIZER_PARITY_EN appends an even-parity beat after the data bits.
module bit_serializer16
    import bit_serializer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [WORD_W-1:0] data_in,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_out,
    output logic              ser_last,
    output logic [SEL_W-1:0]  sel
);

    localparam logic [SEL_W-1:0] SEL_FIRST = sel_first(MSB_FIRST);
    localparam logic [SEL_W-1:0] SEL_LAST  = sel_last(MSB_FIRST);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    ser_state_e        state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              mux_bit;
    logic              beat;
    logic              load;
    logic              at_final_idx;

    MUX161 u_mux (
        .word (word_q),
        .sel  (sel_q),
        .dout (mux_bit)
    );

    assign at_final_idx = (sel_q == SEL_LAST);
    assign sel          = sel_q;
    assign ser_valid    = (state_q == SHIFT);
    assign beat         = ser_valid && ser_ready;
    assign load_ready   = (state_q == IDLE) || (ser_valid && ser_last && ser_ready);
    assign load         = load_valid && load_ready;

`ifdef SERIALIZER_PARITY_EN
    logic parity_phase_q, parity_phase_d;

    assign ser_last = ser_valid && parity_phase_q;
    assign ser_out  = parity_phase_q ? (^word_q) : mux_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_phase_q <= 1'b0;
        end else begin
            parity_phase_q <= parity_phase_d;
        end
    end
`else
    assign ser_last = ser_valid && at_final_idx;
    assign ser_out  = mux_bit;
`endif

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        sel_d   = sel_q;
`ifdef SERIALIZER_PARITY_EN
        parity_phase_d = parity_phase_q;
`endif
        if (load) begin
            // Covers both the idle load and the gapless reload on the final beat.
            state_d = SHIFT;
            word_d  = data_in;
            sel_d   = SEL_FIRST;
`ifdef SERIALIZER_PARITY_EN
            parity_phase_d = 1'b0;
`endif
        end else if (beat) begin
            if (ser_last) begin
                state_d = IDLE;
                sel_d   = SEL_FIRST;
`ifdef SERIALIZER_PARITY_EN
                parity_phase_d = 1'b0;
`endif
`ifdef SERIALIZER_PARITY_EN
            end else if (at_final_idx) begin
                parity_phase_d = 1'b1;
`endif
            end else begin
                sel_d = MSB_FIRST ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            sel_q   <= SEL_FIRST;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_bit_serializer16.sv
// Bench for bit_serializer16: one LSB-first and one MSB-first instance, table-driven words
// plus hand-written stall, back-to-back and mid-word reset sequences.
module tb_bit_serializer16;

`ifdef SERIALIZER_PARITY_EN
    localparam int NB = 17;
`else
    localparam int NB = 16;
`endif

    logic        clk;
    logic        rst_n;
    logic        lv  [2];
    logic [15:0] din [2];
    logic        sr  [2];
    wire         lr  [2];
    wire         sv  [2];
    wire         so  [2];
    wire         sl  [2];
    wire  [3:0]  sel_w [2];

    int checks = 0;
    int errors = 0;

    bit_serializer16 #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[0]), .load_ready(lr[0]), .data_in(din[0]),
        .ser_valid(sv[0]), .ser_ready(sr[0]), .ser_out(so[0]), .ser_last(sl[0]), .sel(sel_w[0])
    );

    bit_serializer16 #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[1]), .load_ready(lr[1]), .data_in(din[1]),
        .ser_valid(sv[1]), .ser_ready(sr[1]), .ser_out(so[1]), .ser_last(sl[1]), .sel(sel_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stream[i] is the bit expected on beat i; par is the expected parity-beat value.
    typedef struct {
        int          m;
        logic [15:0] word;
        logic [15:0] stream;
        logic        par;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_sel(input int m, input int b);
        if (b >= 16) return (m == 1) ? 4'd0 : 4'd15;
        return (m == 1) ? 4'(15 - b) : 4'(b);
    endfunction

    // Entered and left just after a falling edge with the DUT idle.
    task automatic run_word(input vec_t v);
        int m;
        logic expb;
        m = v.m;
        chk("idle_load_ready", 16'(lr[m]), 16'd1);
        chk("idle_ser_valid", 16'(sv[m]), 16'd0);
        lv[m] = 1'b1;
        din[m] = v.word;
        sr[m] = 1'b1;
        @(negedge clk);
        lv[m] = 1'b0;
        din[m] = 16'($urandom_range(0, 65535));
        for (int b = 0; b < NB; b++) begin
            expb = (b < 16) ? v.stream[b] : v.par;
            chk("beat_valid", 16'(sv[m]), 16'd1);
            chk("beat_bit", 16'(so[m]), 16'(expb));
            chk("beat_last", 16'(sl[m]), 16'(b == NB - 1));
            chk("beat_load_ready", 16'(lr[m]), 16'(b == NB - 1));
            chk("beat_sel", 16'(sel_w[m]), 16'(exp_sel(m, b)));
            @(negedge clk);
        end
        chk("done_ser_valid", 16'(sv[m]), 16'd0);
        chk("done_load_ready", 16'(lr[m]), 16'd1);
    endtask

    task automatic stall_test();
        logic [15:0] recv;
        recv = '0;
        lv[0] = 1'b1;
        din[0] = 16'hFFFE;
        sr[0] = 1'b1;
        @(negedge clk);
        lv[0] = 1'b0;
        for (int b = 0; b < NB; b++) begin
            chk("stall_valid", 16'(sv[0]), 16'd1);
            chk("stall_sel", 16'(sel_w[0]), 16'(exp_sel(0, b)));
            if (b < 16) recv[b] = so[0];
            if (b == 7) begin
                sr[0] = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_hold_bit", 16'(so[0]), 16'd1);
                    chk("stall_hold_sel", 16'(sel_w[0]), 16'd7);
                    chk("stall_hold_last", 16'(sl[0]), 16'd0);
                    chk("stall_hold_valid", 16'(sv[0]), 16'd1);
                    chk("stall_hold_load_ready", 16'(lr[0]), 16'd0);
                end
                sr[0] = 1'b1;
            end
            @(negedge clk);
        end
        chk("stall_reassembled", recv, 16'hFFFE);
        chk("stall_done_valid", 16'(sv[0]), 16'd0);
    endtask

    task automatic b2b_test();
        logic [15:0] w0, w1;
        w0 = '0;
        w1 = '0;
        lv[0] = 1'b1;
        din[0] = 16'h1234;
        sr[0] = 1'b1;
        @(negedge clk);
        din[0] = 16'hABCD;
        for (int b = 0; b < 2 * NB; b++) begin
            if (b == NB) begin
                lv[0] = 1'b0;
                din[0] = 16'h0000;
            end
            chk("b2b_valid", 16'(sv[0]), 16'd1);
            if (b == NB - 1) chk("b2b_reload_ready", 16'(lr[0]), 16'd1);
            if (b < 16) w0[b] = so[0];
            else if (b >= NB && b - NB < 16) w1[b - NB] = so[0];
            @(negedge clk);
        end
        chk("b2b_word0", w0, 16'h1234);
        chk("b2b_word1", w1, 16'hABCD);
        chk("b2b_done_valid", 16'(sv[0]), 16'd0);
    endtask

    task automatic reset_mid_word();
        lv[0] = 1'b1;
        din[0] = 16'hA5C3;
        sr[0] = 1'b1;
        @(negedge clk);
        lv[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_reset_sel", 16'(sel_w[0]), 16'd9);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 16'(sv[0]), 16'd0);
        chk("rst_async_load_ready", 16'(lr[0]), 16'd1);
        chk("rst_async_sel", 16'(sel_w[0]), 16'd0);
        chk("rst_async_last", 16'(sl[0]), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{m: 0, word: 16'hA5C3, stream: 16'hA5C3, par: 1'b0};
        tbl[1] = '{m: 1, word: 16'h8001, stream: 16'h8001, par: 1'b0};
        tbl[2] = '{m: 1, word: 16'h00F0, stream: 16'h0F00, par: 1'b0};
        tbl[3] = '{m: 1, word: 16'h1234, stream: 16'h2C48, par: 1'b1};
        tbl[4] = '{m: 0, word: 16'h0007, stream: 16'h0007, par: 1'b1};
        tbl[5] = '{m: 0, word: 16'h0003, stream: 16'h0003, par: 1'b0};
        tbl[6] = '{m: 0, word: 16'h1234, stream: 16'h1234, par: 1'b1};
        tbl[7] = '{m: 0, word: 16'h0F0F, stream: 16'h0F0F, par: 1'b0};

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            lv[i] = 1'b0;
            din[i] = '0;
            sr[i] = 1'b1;
        end
        repeat (2) @(negedge clk);
        chk("reset_lsb_load_ready", 16'(lr[0]), 16'd1);
        chk("reset_lsb_valid", 16'(sv[0]), 16'd0);
        chk("reset_lsb_last", 16'(sl[0]), 16'd0);
        chk("reset_lsb_sel", 16'(sel_w[0]), 16'd0);
        chk("reset_msb_load_ready", 16'(lr[1]), 16'd1);
        chk("reset_msb_valid", 16'(sv[1]), 16'd0);
        chk("reset_msb_sel", 16'(sel_w[1]), 16'd15);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 7; k++) run_word(tbl[k]);

        stall_test();
        b2b_test();
        reset_mid_word();
        run_word(tbl[7]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
